// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_arb_pkg
// Purpose : Op codes, FSM states and flag indices shared by the ALU arbiter.
// Revision: 1.0  initial release
// ============================================================================
package alu_arb_pkg;

  localparam logic [2:0] PASS_B = 3'b000;
  localparam logic [2:0] ADD    = 3'b010;
  localparam logic [2:0] SUB    = 3'b011;
  localparam logic [2:0] AND    = 3'b100;
  localparam logic [2:0] OR     = 3'b101;
  localparam logic [2:0] XOR    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NEG  = 3;
  localparam int ZERO = 2;
  localparam int OVF  = 1;
  localparam int CO   = 0;

  // 001 and 111 have no ALU meaning; their results are discarded.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b111);
  endfunction

  function automatic logic op_arith(input logic [2:0] op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter_if
// Purpose : Request, response and external-ALU signals of the ALU arbiter.
// Revision: 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 64
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_cntrl;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_cntrl;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_illegal;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cntrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carry_out;

  // Requesters plus the external ALU form the master side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_cntrl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cntrl,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_illegal,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_cntrl,
    output alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cntrl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cntrl,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_flags, rsp_illegal,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_cntrl,
    input  alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out
  );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-way round-robin grant with its own priority pointer.
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter2 #(
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // After a grant the pointer favours the requester that just lost.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PRIO_RESET;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Purpose : Shares one external combinational ALU between two requesters.
// Revision: 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int PRIO_RESET = 0
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic [2:0]       cntrl_q;
  logic [2:0]       cntrl_d;
  logic             owner_q;
  logic             owner_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic             illegal_q;
  logic             illegal_d;

  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_accept;
  logic             w_owner_rsp_ready;

  // Requests are only visible to the arbiter while idle.
  assign w_req    = {bus.req1_valid, bus.req0_valid} & {2{state_q == IDLE}};
  assign w_accept = |w_gnt;

  rr_arbiter2 #(
    .PRIO_RESET (PRIO_RESET != 0)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_i    (w_req),
    .accept_i (w_accept),
    .gnt_o    (w_gnt)
  );

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];

  assign w_owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (w_owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cntrl_d = cntrl_q;
    owner_d = owner_q;
    if (w_accept) begin
      a_d     = w_gnt[1] ? bus.req1_a     : bus.req0_a;
      b_d     = w_gnt[1] ? bus.req1_b     : bus.req0_b;
      cntrl_d = w_gnt[1] ? bus.req1_cntrl : bus.req0_cntrl;
      owner_d = w_gnt[1];
    end
  end

  // Only add/sub produce meaningful overflow and carry.
  always_comb begin
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    if (state_q == EXEC) begin
      if (op_illegal(cntrl_q)) begin
        result_d  = '0;
        flags_d   = 4'b0000;
        illegal_d = 1'b1;
      end else begin
        result_d      = bus.alu_result;
        flags_d[NEG]  = bus.alu_negative;
        flags_d[ZERO] = bus.alu_zero;
        flags_d[OVF]  = op_arith(cntrl_q) & bus.alu_overflow;
        flags_d[CO]   = op_arith(cntrl_q) & bus.alu_carry_out;
        illegal_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cntrl_q   <= 3'b000;
      owner_q   <= 1'b0;
      result_q  <= '0;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cntrl_q   <= cntrl_d;
      owner_q   <= owner_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.rsp0_valid  = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid  = (state_q == RESP) &&  owner_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_flags   = flags_q;
  assign bus.rsp_illegal = illegal_q;

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_cntrl = cntrl_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Self-checking bench for alu_arbiter with a stub ALU and model.
// Revision: 1.0  initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W    = 64;
  localparam int PRIO = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W), .PRIO_RESET(PRIO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {logic n; logic z; logic v; logic c; logic [W-1:0] r;} alu_out_t;
  typedef struct packed {logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b;} op_t;
  typedef struct packed {logic [W-1:0] r; logic [3:0] f; logic ill;} exp_t;
  typedef struct {bit rq; logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b;
                  logic [W-1:0] er; logic [3:0] ef; bit ei; int wt;} vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  bit ptr_m;

  // Stub ALU: non-arithmetic ops deliberately report carry/overflow set.
  function automatic alu_out_t alu_stub(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [2:0] op);
    alu_out_t   o;
    logic [W:0] s;
    case (op)
      ADD:     s = {1'b0, a} + {1'b0, b};
      SUB:     s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      PASS_B:  s = {1'b1, b};
      AND:     s = {1'b1, a & b};
      OR:      s = {1'b1, a | b};
      XOR:     s = {1'b1, a ^ b};
      default: s = {1'b1, a ^ ~b};
    endcase
    o.r = s[W-1:0];
    o.c = s[W];
    o.n = o.r[W-1];
    o.z = (o.r == '0);
    if (op == ADD)      o.v = (a[W-1] == b[W-1]) && (o.r[W-1] != a[W-1]);
    else if (op == SUB) o.v = (a[W-1] != b[W-1]) && (o.r[W-1] != a[W-1]);
    else                o.v = 1'b1;
    return o;
  endfunction

  assign {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry_out,
          bus.alu_result} = alu_stub(bus.alu_a, bus.alu_b, bus.alu_cntrl);

  function automatic exp_t expect_of(input op_t p);
    alu_out_t o;
    exp_t     e;
    o = alu_stub(p.a, p.b, p.op);
    if (p.op == 3'b001 || p.op == 3'b111) begin
      e = '{r: '0, f: 4'b0000, ill: 1'b1};
    end else if (p.op == ADD || p.op == SUB) begin
      e = '{r: o.r, f: {o.n, o.z, o.v, o.c}, ill: 1'b0};
    end else begin
      e = '{r: o.r, f: {o.n, o.z, 2'b00}, ill: 1'b0};
    end
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t p;
    p.op = 3'($urandom_range(0, 7));
    p.a  = {$urandom, $urandom};
    p.b  = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) p.a = '1;
    if ($urandom_range(0, 3) == 0) p.b = 64'd1;
    return p;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  task automatic drive(input bit v0, input bit v1, input op_t p0, input op_t p1);
    bus.req0_valid = v0; bus.req0_cntrl = p0.op; bus.req0_a = p0.a; bus.req0_b = p0.b;
    bus.req1_valid = v1; bus.req1_cntrl = p1.op; bus.req1_a = p1.a; bus.req1_b = p1.b;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr_m = 1'(PRIO);
    #1;
  endtask

  // One complete transaction; wt = cycles the owner holds off rsp_ready.
  task automatic issue(input bit v0, input bit v1, input op_t p0, input op_t p1,
                       input int wt, input exp_t e0, input exp_t e1);
    bit   er;
    exp_t e;
    op_t  p;
    int   waited;
    er = (v0 && v1) ? ptr_m : v1;
    e  = er ? e1 : e0;
    p  = er ? p1 : p0;
    @(negedge clk);
    drive(v0, v1, p0, p1);
    #1;
    waited = 0;
    while (!(bus.req0_ready || bus.req1_ready) && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!(bus.req0_ready || bus.req1_ready)) begin
      fail_now("req_ready");
      drive(1'b0, 1'b0, '0, '0);
      return;
    end
    chk("ready_first_cycle", waited, 0);
    chk("grant", {bus.req1_ready, bus.req0_ready}, er ? 2'b10 : 2'b01);
    ptr_m = !er;
    @(posedge clk);
    @(negedge clk);
    if (er) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
    bus.rsp0_ready = er;
    bus.rsp1_ready = !er;
    #1;
    chk("exec_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    chk("exec_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
    chk("alu_a", bus.alu_a, p.a);
    chk("alu_b", bus.alu_b, p.b);
    chk("alu_cntrl", bus.alu_cntrl, p.op);
    for (int i = 0; i <= wt; i++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (i == wt) begin
        if (er) bus.rsp1_ready = 1'b1;
        else    bus.rsp0_ready = 1'b1;
      end
      #1;
      chk("rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, er ? 2'b10 : 2'b01);
      chk("rsp_result", bus.rsp_result, e.r);
      chk("rsp_flags", bus.rsp_flags, e.f);
      chk("rsp_illegal", bus.rsp_illegal, e.ill);
      chk("resp_req_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    end
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("rsp_released", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    exp_t te;
    op_t  tp;
    op_t  p0;
    op_t  p1;
    exp_t ex;
    bit   r;
    bit   er;
    int   waited;

    tbl[0]  = '{0, ADD,    64'd7000, 64'd1888, 64'd8888, 4'b0000, 0, 0};
    tbl[1]  = '{1, SUB,    64'd0, 64'd124, 64'hFFFF_FFFF_FFFF_FF84, 4'b1000, 0, 5};
    tbl[2]  = '{0, ADD,    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0101, 0, 1};
    tbl[3]  = '{0, AND,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 0, 0};
    tbl[4]  = '{1, 3'b111, 64'd9, 64'd3, 64'd0, 4'b0000, 1, 2};
    tbl[5]  = '{1, ADD,    64'd5, 64'd6, 64'd11, 4'b0000, 0, 0};
    tbl[6]  = '{0, SUB,    64'd5, 64'd5, 64'd0, 4'b0101, 0, 0};
    tbl[7]  = '{1, PASS_B, 64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b1000, 0, 1};
    tbl[8]  = '{0, XOR,    64'hF0, 64'hFF, 64'h0F, 4'b0000, 0, 0};
    tbl[9]  = '{1, OR,     64'd0, 64'd0, 64'd0, 4'b0100, 0, 0};
    tbl[10] = '{0, 3'b001, 64'd1, 64'd1, 64'd0, 4'b0000, 1, 0};
    tbl[11] = '{1, ADD,    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010, 0, 0};

    reset_dut();
    chk("reset_req_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    chk("reset_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
    chk("reset_result", bus.rsp_result, '0);
    chk("reset_flags", bus.rsp_flags, 4'b0000);
    chk("reset_illegal", bus.rsp_illegal, 1'b0);
    chk("reset_alu_a", bus.alu_a, '0);
    chk("reset_alu_b", bus.alu_b, '0);
    chk("reset_alu_cntrl", bus.alu_cntrl, 3'b000);

    for (int i = 0; i < 12; i++) begin
      tp = '{op: tbl[i].op, a: tbl[i].a, b: tbl[i].b};
      te = '{r: tbl[i].er, f: tbl[i].ef, ill: tbl[i].ei};
      issue(!tbl[i].rq, tbl[i].rq, tp, tp, tbl[i].wt, te, te);
    end

    for (int i = 0; i < 30; i++) begin
      p0 = rand_op();
      p1 = rand_op();
      case ($urandom_range(0, 2))
        0:       issue(1'b1, 1'b0, p0, p1, $urandom_range(0, 3), expect_of(p0), expect_of(p1));
        1:       issue(1'b0, 1'b1, p0, p1, $urandom_range(0, 3), expect_of(p0), expect_of(p1));
        default: issue(1'b1, 1'b1, p0, p1, $urandom_range(0, 3), expect_of(p0), expect_of(p1));
      endcase
    end

    // Both requesters held valid: grants must alternate from PRIO.
    reset_dut();
    p0 = rand_op();
    p1 = rand_op();
    drive(1'b1, 1'b1, p0, p1);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      while (!(bus.req0_ready || bus.req1_ready) && waited < 8) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!(bus.req0_ready || bus.req1_ready)) begin
        fail_now("alt_ready");
        break;
      end
      er = (k % 2 == 0) ? 1'(PRIO) : !1'(PRIO);
      r  = bus.req1_ready;
      chk("alt_grant", {bus.req1_ready, bus.req0_ready}, er ? 2'b10 : 2'b01);
      ex = expect_of(r ? p1 : p0);
      @(posedge clk);
      @(negedge clk);
      if (r) p1 = rand_op();
      else   p0 = rand_op();
      drive(1'b1, 1'b1, p0, p1);
      @(negedge clk);
      #1;
      chk("alt_owner_only", {bus.rsp1_valid, bus.rsp0_valid}, r ? 2'b10 : 2'b01);
      chk("alt_result", bus.rsp_result, ex.r);
      chk("alt_flags", bus.rsp_flags, ex.f);
      @(negedge clk);
      #1;
    end
    drive(1'b0, 1'b0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset while an op from requester 0 is executing.
    reset_dut();
    p0 = '{op: ADD, a: 64'd1, b: 64'd2};
    drive(1'b1, 1'b0, p0, '0);
    #1;
    chk("mid_ready0", bus.req0_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 1'(PRIO);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mid_no_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
      @(negedge clk);
    end
    chk("mid_alu_a", bus.alu_a, '0);
    p0 = rand_op();
    p1 = rand_op();
    issue(1'b1, 1'b1, p0, p1, 0, expect_of(p0), expect_of(p1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
